// File: rtl/soma_run_ctrl.sv
// soma_run_ctrl: launches a run on a set of kernels and tracks it.
// The run ends when every selected kernel has finished, on a timeout, or on reset.
module soma_run_ctrl #(
    parameter int NUM_KERNELS = 2,
    parameter int CNT_W       = 64,
    parameter int TMO_W       = 32
) (
    input  logic                   clk,
    input  logic                   SoftReset,
    input  logic                   start,
    input  logic [NUM_KERNELS-1:0] kernel_mask,
    input  logic [TMO_W-1:0]       timeout_cycles,
    output logic [NUM_KERNELS-1:0] kernel_start,
    input  logic [NUM_KERNELS-1:0] kernel_finish,
    output logic                   finish,
    output logic                   busy,
    output logic                   timed_out,
    output logic [NUM_KERNELS-1:0] done_vec,
    output logic [CNT_W-1:0]       run_cycles,
    output logic [31:0]            run_count
);

    localparam int MW = (CNT_W > TMO_W) ? CNT_W : TMO_W;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        RUN,
        DONE
    } stateT;

    stateT                  state;
    stateT                  nextState;
    logic                   startQ;
    logic                   startEdge;
    logic [NUM_KERNELS-1:0] maskQ;
    logic [TMO_W-1:0]       tmoQ;
    logic [NUM_KERNELS-1:0] finSeen;
    logic                   allDone;
    logic                   tmoHit;
    logic [MW-1:0]          cyclesExt;
    logic [MW-1:0]          tmoExt;

    assign startEdge = start & ~startQ;
    assign finSeen   = done_vec | (kernel_finish & maskQ);
    assign allDone   = (finSeen == maskQ);
    assign cyclesExt = MW'(run_cycles);
    assign tmoExt    = MW'(tmoQ);
    assign tmoHit    = (tmoQ != '0) && (cyclesExt >= tmoExt);

    // State register; reset aborts any run immediately
    always_ff @(posedge clk or posedge SoftReset) begin
        if (SoftReset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state: launch on a fresh edge, finish on completion or timeout
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (startEdge) nextState = LAUNCH;
            LAUNCH:  nextState = RUN;
            RUN:     if (allDone || tmoHit) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Outputs decoded from the current state only
    always_comb begin
        kernel_start = '0;
        finish       = 1'b0;
        busy         = (state != IDLE);
        if (state == LAUNCH) kernel_start = maskQ;
        if (state == DONE)   finish       = 1'b1;
    end

    // Run bookkeeping: launch capture, cycle count, finish flags, run tally
    always_ff @(posedge clk or posedge SoftReset) begin
        if (SoftReset) begin
            startQ     <= 1'b1;
            maskQ      <= '0;
            tmoQ       <= '0;
            done_vec   <= '0;
            run_cycles <= '0;
            timed_out  <= 1'b0;
            run_count  <= '0;
        end else begin
            startQ <= start;
            unique case (state)
                IDLE: begin
                    if (startEdge) begin
                        maskQ      <= kernel_mask;
                        tmoQ       <= timeout_cycles;
                        done_vec   <= '0;
                        run_cycles <= '0;
                        timed_out  <= 1'b0;
                    end
                end
                LAUNCH: begin
                    if (!(&run_cycles)) run_cycles <= run_cycles + CNT_W'(1);
                end
                RUN: begin
                    if (!(&run_cycles)) run_cycles <= run_cycles + CNT_W'(1);
                    done_vec <= finSeen;
                    if (!allDone && tmoHit) timed_out <= 1'b1;
                end
                DONE: begin
                    run_count <= run_count + 32'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_soma_run_ctrl.sv
// tb_soma_run_ctrl: directed scenarios for soma_run_ctrl.
// Each task drives one scenario and checks its own hand-computed values.
module tb_soma_run_ctrl;

    logic        clk;
    logic        SoftReset;
    logic        start;
    logic [1:0]  kernel_mask;
    logic [31:0] timeout_cycles;
    logic [1:0]  kernel_start;
    logic [1:0]  kernel_finish;
    logic        finish;
    logic        busy;
    logic        timed_out;
    logic [1:0]  done_vec;
    logic [63:0] run_cycles;
    logic [31:0] run_count;

    int nTests = 0;
    int nFail  = 0;
    int ksCnt  = 0;
    int finCnt = 0;

    soma_run_ctrl #(
        .NUM_KERNELS(2),
        .CNT_W(64),
        .TMO_W(32)
    ) dut (
        .clk(clk),
        .SoftReset(SoftReset),
        .start(start),
        .kernel_mask(kernel_mask),
        .timeout_cycles(timeout_cycles),
        .kernel_start(kernel_start),
        .kernel_finish(kernel_finish),
        .finish(finish),
        .busy(busy),
        .timed_out(timed_out),
        .done_vec(done_vec),
        .run_cycles(run_cycles),
        .run_count(run_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count cycles carrying a start pulse or a finish pulse
    always @(negedge clk) begin
        if (|kernel_start) ksCnt++;
        if (finish) finCnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start low for one edge, then high: the next edge samples the launch
    task automatic launch(input logic [1:0] m, input logic [31:0] t);
        start = 1'b0;
        tick();
        kernel_mask    = m;
        timeout_cycles = t;
        start          = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        start         = 1'b1;
        kernel_finish = 2'b00;
        SoftReset     = 1'b1;
        tick();
        tick();
        #2;
        SoftReset = 1'b0;
        tick();
        nTests++;
        if ({busy, finish, timed_out, kernel_start, done_vec} !== 7'b0) begin
            nFail++;
            $display("FAIL reset_flags: got %b exp 0",
                     {busy, finish, timed_out, kernel_start, done_vec});
        end
        nTests++;
        if (run_cycles !== 64'd0 || run_count !== 32'd0) begin
            nFail++;
            $display("FAIL reset_counts: got %0d/%0d exp 0/0", run_cycles, run_count);
        end
        tick();
        tick();
        nTests++;
        if (busy !== 1'b0) begin
            nFail++;
            $display("FAIL reset_held_start: busy got %b exp 0", busy);
        end
    endtask

    task automatic test_basic();
        int ks0;
        int fin0;
        ks0  = ksCnt;
        fin0 = finCnt;
        launch(2'b11, 32'd0);
        nTests++;
        if (kernel_start !== 2'b11 || busy !== 1'b1) begin
            nFail++;
            $display("FAIL basic_launch: ks %b busy %b exp 11 1", kernel_start, busy);
        end
        tick();
        tick();
        tick();
        kernel_finish = 2'b01;
        tick();
        kernel_finish = 2'b00;
        nTests++;
        if (done_vec !== 2'b01 || finish !== 1'b0) begin
            nFail++;
            $display("FAIL basic_k0: done %b fin %b exp 01 0", done_vec, finish);
        end
        tick();
        kernel_finish = 2'b10;
        tick();
        kernel_finish = 2'b00;
        nTests++;
        if (finish !== 1'b1 || done_vec !== 2'b11 || run_cycles !== 64'd6) begin
            nFail++;
            $display("FAIL basic_done: fin %b done %b cyc %0d exp 1 11 6",
                     finish, done_vec, run_cycles);
        end
        tick();
        nTests++;
        if (finish !== 1'b0 || busy !== 1'b0 || run_count !== 32'd1) begin
            nFail++;
            $display("FAIL basic_idle: fin %b busy %b cnt %0d exp 0 0 1",
                     finish, busy, run_count);
        end
        nTests++;
        if (ksCnt - ks0 !== 1 || finCnt - fin0 !== 1) begin
            nFail++;
            $display("FAIL basic_pulses: ks %0d fin %0d exp 1 1",
                     ksCnt - ks0, finCnt - fin0);
        end
    endtask

    task automatic test_timeout();
        launch(2'b01, 32'd10);
        for (int i = 0; i < 10; i++) tick();
        nTests++;
        if (finish !== 1'b0 || busy !== 1'b1) begin
            nFail++;
            $display("FAIL tmo_early: fin %b busy %b exp 0 1", finish, busy);
        end
        tick();
        nTests++;
        if (finish !== 1'b1 || timed_out !== 1'b1 || done_vec !== 2'b00
            || run_cycles !== 64'd11) begin
            nFail++;
            $display("FAIL tmo_done: fin %b tmo %b done %b cyc %0d exp 1 1 00 11",
                     finish, timed_out, done_vec, run_cycles);
        end
        tick();
        nTests++;
        if (busy !== 1'b0 || timed_out !== 1'b1 || run_count !== 32'd2) begin
            nFail++;
            $display("FAIL tmo_hold: busy %b tmo %b cnt %0d exp 0 1 2",
                     busy, timed_out, run_count);
        end
    endtask

    task automatic test_tmo_tie();
        launch(2'b11, 32'd4);
        nTests++;
        if (timed_out !== 1'b0) begin
            nFail++;
            $display("FAIL tie_clear: tmo got %b exp 0", timed_out);
        end
        tick();
        kernel_finish = 2'b01;
        tick();
        kernel_finish = 2'b00;
        tick();
        tick();
        kernel_finish = 2'b10;
        tick();
        kernel_finish = 2'b00;
        nTests++;
        if (finish !== 1'b1 || timed_out !== 1'b0 || done_vec !== 2'b11
            || run_cycles !== 64'd5) begin
            nFail++;
            $display("FAIL tie_done: fin %b tmo %b done %b cyc %0d exp 1 0 11 5",
                     finish, timed_out, done_vec, run_cycles);
        end
        tick();
        nTests++;
        if (run_count !== 32'd3 || timed_out !== 1'b0) begin
            nFail++;
            $display("FAIL tie_cnt: cnt %0d tmo %b exp 3 0", run_count, timed_out);
        end
    endtask

    task automatic test_zero_mask();
        int ks0;
        ks0 = ksCnt;
        launch(2'b00, 32'd0);
        nTests++;
        if (kernel_start !== 2'b00 || busy !== 1'b1) begin
            nFail++;
            $display("FAIL zero_launch: ks %b busy %b exp 00 1", kernel_start, busy);
        end
        tick();
        nTests++;
        if (finish !== 1'b0) begin
            nFail++;
            $display("FAIL zero_early: fin got %b exp 0", finish);
        end
        tick();
        nTests++;
        if (finish !== 1'b1 || run_cycles !== 64'd2) begin
            nFail++;
            $display("FAIL zero_done: fin %b cyc %0d exp 1 2", finish, run_cycles);
        end
        tick();
        nTests++;
        if (run_count !== 32'd4 || ksCnt !== ks0) begin
            nFail++;
            $display("FAIL zero_end: cnt %0d ks %0d exp 4 %0d", run_count, ksCnt, ks0);
        end
    endtask

    task automatic test_ignored();
        int fin0;
        fin0          = finCnt;
        kernel_finish = 2'b11;
        tick();
        tick();
        kernel_finish = 2'b00;
        nTests++;
        if (done_vec !== 2'b00 || busy !== 1'b0) begin
            nFail++;
            $display("FAIL ign_idle: done %b busy %b exp 00 0", done_vec, busy);
        end
        launch(2'b01, 32'd0);
        kernel_finish = 2'b01;
        tick();
        kernel_finish = 2'b00;
        nTests++;
        if (done_vec !== 2'b00 || busy !== 1'b1) begin
            nFail++;
            $display("FAIL ign_launch: done %b busy %b exp 00 1", done_vec, busy);
        end
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        kernel_finish = 2'b10;
        tick();
        kernel_finish = 2'b00;
        nTests++;
        if (done_vec !== 2'b00 || busy !== 1'b1 || finish !== 1'b0) begin
            nFail++;
            $display("FAIL ign_unmasked: done %b busy %b fin %b exp 00 1 0",
                     done_vec, busy, finish);
        end
        kernel_finish = 2'b01;
        tick();
        kernel_finish = 2'b00;
        nTests++;
        if (finish !== 1'b1 || done_vec !== 2'b01 || run_cycles !== 64'd5) begin
            nFail++;
            $display("FAIL ign_done: fin %b done %b cyc %0d exp 1 01 5",
                     finish, done_vec, run_cycles);
        end
        for (int i = 0; i < 4; i++) tick();
        nTests++;
        if (busy !== 1'b0 || run_count !== 32'd5 || finCnt - fin0 !== 1) begin
            nFail++;
            $display("FAIL ign_norerun: busy %b cnt %0d fins %0d exp 0 5 1",
                     busy, run_count, finCnt - fin0);
        end
    endtask

    task automatic test_reset_mid();
        int fin0;
        launch(2'b11, 32'd0);
        tick();
        kernel_finish = 2'b01;
        tick();
        kernel_finish = 2'b00;
        nTests++;
        if (done_vec !== 2'b01 || busy !== 1'b1) begin
            nFail++;
            $display("FAIL mid_pre: done %b busy %b exp 01 1", done_vec, busy);
        end
        fin0      = finCnt;
        SoftReset = 1'b1;
        #2;
        nTests++;
        if ({busy, finish, timed_out, kernel_start, done_vec} !== 7'b0
            || run_cycles !== 64'd0 || run_count !== 32'd0) begin
            nFail++;
            $display("FAIL mid_abort: flags %b cyc %0d cnt %0d exp 0 0 0",
                     {busy, finish, timed_out, kernel_start, done_vec},
                     run_cycles, run_count);
        end
        tick();
        SoftReset = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        nTests++;
        if (busy !== 1'b0 || finCnt !== fin0 || run_count !== 32'd0) begin
            nFail++;
            $display("FAIL mid_norelaunch: busy %b fins %0d cnt %0d exp 0 0 0",
                     busy, finCnt - fin0, run_count);
        end
        launch(2'b11, 32'd0);
        nTests++;
        if (busy !== 1'b1 || kernel_start !== 2'b11) begin
            nFail++;
            $display("FAIL mid_relaunch: busy %b ks %b exp 1 11", busy, kernel_start);
        end
        tick();
        kernel_finish = 2'b11;
        tick();
        kernel_finish = 2'b00;
        tick();
        nTests++;
        if (run_count !== 32'd1 || busy !== 1'b0) begin
            nFail++;
            $display("FAIL mid_after: cnt %0d busy %b exp 1 0", run_count, busy);
        end
    endtask

    initial begin
        SoftReset      = 1'b1;
        start          = 1'b0;
        kernel_mask    = 2'b00;
        timeout_cycles = 32'd0;
        kernel_finish  = 2'b00;
        test_reset();
        test_basic();
        test_timeout();
        test_tmo_tie();
        test_zero_mask();
        test_ignored();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
